fwd_scoreboard: RTL and testbench

Parametrised successor to the fixed 2-read-port regfile plus bypass network: one block holding the architectural register file, per-register pending-write counters and an N-stage forwarding mux. Sits between ID and the EX..WB stages of the in-order pipeline. Supplies ID with forwarded operands and a single stall. Generalises read-port count and forwarded-stage count, and adds multi-in-flight-write tracking and flush recovery, which the old bypass lacked.

---
 rtl/fwd_scoreboard_pkg.sv | 14 +
 rtl/fwd_scoreboard_if.sv | 39 +++
 rtl/fwd_sb_regfile.sv | 47 ++++
 rtl/fwd_scoreboard.sv | 143 ++++++++++++++
 tb/tb_fwd_scoreboard.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared defaults and flat-bus slicing helper for the forwarding scoreboard.
package fwd_scoreboard_pkg;
  localparam int DEF_NREG = 32;
  localparam int DEF_AW   = 5;
  localparam int DEF_DW   = 32;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NST  = 3;
  localparam int DEF_CW   = 2;

  // Low bit of lane `lane` in a flat bus of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/fwd_scoreboard_if.sv
// ID / pipeline-stage / WB bundle between the in-order pipeline and the scoreboard.
interface fwd_scoreboard_if #(
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int NRD = 2,
  parameter int NST = 3
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              rd_stall;
  logic              id_issue;
  logic              id_we;
  logic [AW-1:0]     id_waddr;
  logic [NST-1:0]    st_valid;
  logic [NST-1:0]    st_we;
  logic [NST*AW-1:0] st_waddr;
  logic [NST-1:0]    st_data_ok;
  logic [NST*DW-1:0] st_wdata;
  logic              wb_valid;
  logic              wb_we;
  logic [AW-1:0]     wb_waddr;
  logic [DW-1:0]     wb_wdata;
  logic              flush;
  logic              pend_any;

  modport master (
    output rd_addr, id_issue, id_we, id_waddr,
    output st_valid, st_we, st_waddr, st_data_ok, st_wdata,
    output wb_valid, wb_we, wb_waddr, wb_wdata, flush,
    input  rd_data, rd_stall, pend_any
  );

  modport slave (
    input  rd_addr, id_issue, id_we, id_waddr,
    input  st_valid, st_we, st_waddr, st_data_ok, st_wdata,
    input  wb_valid, wb_we, wb_waddr, wb_wdata, flush,
    output rd_data, rd_stall, pend_any
  );
endinterface

// File: rtl/fwd_sb_regfile.sv
// Architectural register file: NRD combinational read ports, one write port, r0 reads zero.
module fwd_sb_regfile
  import fwd_scoreboard_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int NRD  = DEF_NRD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
);
  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      mem_d[r] = mem_q[r];
    end
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        mem_q[r] <= mem_d[r];
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] a;
    assign a = raddr[lane_lo(gi, AW) +: AW];
    assign rdata[lane_lo(gi, DW) +: DW] = (a == '0) ? '0 : mem_q[a];
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// Register file + per-register pending-write counters + NST-stage forwarding mux.
// Supplies ID with forwarded operands and one stall covering hazards and counter overflow.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int NRD  = DEF_NRD,
  parameter int NST  = DEF_NST,
  parameter int CW   = DEF_CW
) (
  input logic             clk,
  input logic             resetn,
  fwd_scoreboard_if.slave bus
);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0]     cnt_q [NREG];
  logic [CW-1:0]     cnt_d [NREG];
  logic [NREG-1:0]   cnt_nz;
  logic [NRD*DW-1:0] rf_rdata;
  logic [NRD*DW-1:0] port_data;
  logic [NRD-1:0]    port_stall;
  logic              wb_commit;
  logic              ovf_stall;
  logic              stall_all;
  logic              inc_en;
  logic              same_reg;

  assign wb_commit = bus.wb_valid && bus.wb_we && (bus.wb_waddr != '0);

  fwd_sb_regfile #(
    .NREG(NREG), .AW(AW), .DW(DW), .NRD(NRD)
  ) u_rf (
    .clk   (clk),
    .resetn(resetn),
    .we    (wb_commit),
    .waddr (bus.wb_waddr),
    .wdata (bus.wb_wdata),
    .raddr (bus.rd_addr),
    .rdata (rf_rdata)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic [AW-1:0] addr;
    logic          st_hit;
    logic          st_ok;
    logic [DW-1:0] st_val;
    logic          p_stall;
    logic [DW-1:0] p_data;

    assign addr = bus.rd_addr[lane_lo(gi, AW) +: AW];

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
      st_hit = 1'b0;
      st_ok  = 1'b0;
      st_val = '0;
      for (int i = NST - 1; i >= 0; i--) begin
        if (bus.st_valid[i] && bus.st_we[i] &&
            (bus.st_waddr[lane_lo(i, AW) +: AW] == addr)) begin
          st_hit = 1'b1;
          st_ok  = bus.st_data_ok[i];
          st_val = bus.st_wdata[lane_lo(i, DW) +: DW];
        end
      end
    end

    // A non-zero counter with no visible writer means the producer sits in an unexposed stage.
    always_comb begin
      p_stall = 1'b0;
      p_data  = '0;
      if (addr != '0) begin
        if (st_hit) begin
          p_stall = !st_ok;
          p_data  = st_val;
        end else if (wb_commit && (bus.wb_waddr == addr)) begin
          p_data = bus.wb_wdata;
        end else if (cnt_q[addr] != '0) begin
          p_stall = 1'b1;
        end else begin
          p_data = rf_rdata[lane_lo(gi, DW) +: DW];
        end
      end
    end

    assign port_stall[gi]                 = p_stall;
    assign port_data[lane_lo(gi, DW) +: DW] = p_data;
  end

  assign same_reg  = wb_commit && (bus.wb_waddr == bus.id_waddr);
  assign ovf_stall = bus.id_we && (bus.id_waddr != '0) &&
                     (cnt_q[bus.id_waddr] == CNT_MAX) && !same_reg;
  assign stall_all = (|port_stall) || ovf_stall;
  assign inc_en    = bus.id_issue && !stall_all && bus.id_we &&
                     (bus.id_waddr != '0) && !bus.flush;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (bus.flush) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
    end else if (!(inc_en && same_reg)) begin
      if (inc_en) begin
        cnt_d[bus.id_waddr] = cnt_q[bus.id_waddr] + CW'(1);
      end
      if (wb_commit && (cnt_q[bus.wb_waddr] != '0)) begin
        cnt_d[bus.wb_waddr] = cnt_q[bus.wb_waddr] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wb_commit) begin
      assert (cnt_q[bus.wb_waddr] != '0)
        else $error("fwd_scoreboard: WB to r%0d with no pending write", bus.wb_waddr);
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_nz
    assign cnt_nz[gi] = |cnt_q[gi];
  end

  assign bus.rd_data  = port_data;
  assign bus.rd_stall = stall_all;
  assign bus.pend_any = |cnt_nz;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: forwarding priority, stalls, counter saturation, flush, reset.
module tb_fwd_scoreboard;
  import fwd_scoreboard_pkg::*;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NRD  = 2;
  localparam int NST  = 3;
  localparam int CW   = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fwd_scoreboard_if #(.AW(AW), .DW(DW), .NRD(NRD), .NST(NST)) bus_if ();

  fwd_scoreboard #(
    .NREG(NREG), .AW(AW), .DW(DW), .NRD(NRD), .NST(NST), .CW(CW)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-16s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic idle();
    bus_if.rd_addr    = '0;
    bus_if.id_issue   = 1'b0;
    bus_if.id_we      = 1'b0;
    bus_if.id_waddr   = '0;
    bus_if.st_valid   = '0;
    bus_if.st_we      = '0;
    bus_if.st_waddr   = '0;
    bus_if.st_data_ok = '0;
    bus_if.st_wdata   = '0;
    bus_if.wb_valid   = 1'b0;
    bus_if.wb_we      = 1'b0;
    bus_if.wb_waddr   = '0;
    bus_if.wb_wdata   = '0;
    bus_if.flush      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    bus_if.rd_addr[port*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    bus_if.id_issue = 1'b1;
    bus_if.id_we    = 1'b1;
    bus_if.id_waddr = a;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_if.wb_valid = 1'b1;
    bus_if.wb_we    = 1'b1;
    bus_if.wb_waddr = a;
    bus_if.wb_wdata = d;
  endtask

  task automatic stage(input int i, input logic [AW-1:0] a, input logic ok, input logic [DW-1:0] d);
    bus_if.st_valid[i]            = 1'b1;
    bus_if.st_we[i]               = 1'b1;
    bus_if.st_waddr[i*AW +: AW]   = a;
    bus_if.st_data_ok[i]          = ok;
    bus_if.st_wdata[i*DW +: DW]   = d;
  endtask

  function automatic logic [DW-1:0] rdp(input int port);
    return bus_if.rd_data[port*DW +: DW];
  endfunction

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rd(0, 5);
    #1;
    chk ("rst_rd_data", rdp(0), 32'h0);
    chkb("rst_stall", bus_if.rd_stall, 1'b0);
    chkb("rst_pend", bus_if.pend_any, 1'b0);
    resetn = 1'b1;

    // r5: issue, hidden producer stalls, WB write-through then array read
    step(); issue(5); #1;
    chkb("r5_issue_stall", bus_if.rd_stall, 1'b0);
    step(); #1;
    chkb("r5_pend", bus_if.pend_any, 1'b1);
    rd(0, 5); #1;
    chkb("r5_cnt_stall", bus_if.rd_stall, 1'b1);
    wb(5, 32'h1234); #1;
    chk ("r5_wthru", rdp(0), 32'h1234);
    chkb("r5_wthru_stall", bus_if.rd_stall, 1'b0);
    step(); rd(0, 5); #1;
    chk ("r5_array", rdp(0), 32'h1234);
    chkb("r5_array_stall", bus_if.rd_stall, 1'b0);
    chkb("r5_pend_clr", bus_if.pend_any, 1'b0);

    // r3: EX forwarding on port 1, r0 immune to stage claims
    step(); issue(3);
    step(); stage(0, 3, 1'b1, 32'hAA); rd(1, 3); #1;
    chk ("r3_fwd", rdp(1), 32'hAA);
    chkb("r3_fwd_stall", bus_if.rd_stall, 1'b0);
    stage(1, 0, 1'b0, 32'hDEAD); rd(0, 0); #1;
    chk ("r0_data", rdp(0), 32'h0);
    chkb("r0_stall", bus_if.rd_stall, 1'b0);
    step(); rd(1, 3); #1;
    chkb("r3_hidden_stall", bus_if.rd_stall, 1'b1);
    wb(3, 32'hAA); #1;
    chk ("r3_wb_thru", rdp(1), 32'hAA);

    // r4: load in EX stalls, result arriving in stage 1 releases
    step(); issue(4);
    step(); stage(0, 4, 1'b0, 32'h0); rd(0, 4); #1;
    chkb("r4_load_stall", bus_if.rd_stall, 1'b1);
    step(); stage(1, 4, 1'b1, 32'h55); rd(0, 4); #1;
    chkb("r4_ret_stall", bus_if.rd_stall, 1'b0);
    chk ("r4_ret_data", rdp(0), 32'h55);
    step(); wb(4, 32'h55);

    // r7: two writers, youngest wins
    step(); issue(7);
    step(); issue(7);
    step(); stage(0, 7, 1'b1, 32'h2); stage(2, 7, 1'b1, 32'h1); rd(0, 7); rd(1, 7); #1;
    chk ("r7_young_p0", rdp(0), 32'h2);
    chk ("r7_young_p1", rdp(1), 32'h2);
    bus_if.st_valid[0] = 1'b0; #1;
    chk ("r7_old", rdp(0), 32'h1);
    chkb("r7_old_stall", bus_if.rd_stall, 1'b0);
    step(); wb(7, 32'h1);
    step(); wb(7, 32'h2);
    step(); rd(0, 7); #1;
    chk ("r7_array", rdp(0), 32'h2);
    chkb("r7_pend_clr", bus_if.pend_any, 1'b0);

    // r9: saturate the counter, overflow stall, same-cycle WB relief
    for (int n = 0; n < 3; n++) begin
      step(); issue(9); #1;
      chkb($sformatf("r9_issue%0d", n), bus_if.rd_stall, 1'b0);
    end
    step(); issue(9); #1;
    chkb("r9_ovf_stall", bus_if.rd_stall, 1'b1);
    step(); issue(9); #1;
    chkb("r9_ovf_again", bus_if.rd_stall, 1'b1);
    wb(9, 32'h99); #1;
    chkb("r9_ovf_wb", bus_if.rd_stall, 1'b0);
    step(); bus_if.id_we = 1'b1; bus_if.id_waddr = 9; #1;
    chkb("r9_still_full", bus_if.rd_stall, 1'b1);
    step(); wb(9, 32'h99);
    step(); bus_if.id_we = 1'b1; bus_if.id_waddr = 9; #1;
    chkb("r9_below_max", bus_if.rd_stall, 1'b0);
    chkb("r9_pend", bus_if.pend_any, 1'b1);

    // flush with same-cycle WB r2 and a dropped issue of r11
    step(); issue(2);
    step(); issue(6);
    step(); issue(6);
    step(); bus_if.flush = 1'b1; wb(2, 32'h9); issue(11); #1;
    chkb("flush_pend_pre", bus_if.pend_any, 1'b1);
    step(); rd(0, 2); rd(1, 11); #1;
    chkb("flush_pend", bus_if.pend_any, 1'b0);
    chk ("flush_r2", rdp(0), 32'h9);
    chk ("flush_r11", rdp(1), 32'h0);
    chkb("flush_stall", bus_if.rd_stall, 1'b0);
    rd(1, 9); #1;
    chk ("flush_r9", rdp(1), 32'h99);

    // mid-run asynchronous reset
    step(); issue(9);
    step(); issue(9);
    step(); issue(9);
    step(); bus_if.id_we = 1'b1; bus_if.id_waddr = 9; rd(0, 5); #1;
    chkb("pre_rst_stall", bus_if.rd_stall, 1'b1);
    chkb("pre_rst_pend", bus_if.pend_any, 1'b1);
    chk ("pre_rst_r5", rdp(0), 32'h1234);
    resetn = 1'b0; #1;
    chkb("mid_rst_stall", bus_if.rd_stall, 1'b0);
    chkb("mid_rst_pend", bus_if.pend_any, 1'b0);
    chk ("mid_rst_r5", rdp(0), 32'h0);
    step();
    resetn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
